// File: rtl/stack_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : stack_ctrl_v2
//  Purpose  : Multicycle controller for the stack-machine datapath. Fetches an
//             instruction into IR, decodes the 4-bit opcode and issues one
//             micro-step of datapath strobes per clock. Tracks stack occupancy
//             internally and supports a start/halt handshake.
//  Optional : STACK_GUARD_EN -- when defined, occupancy and illegal-opcode
//             checks in ID send the controller to FAULT; otherwise fault is
//             tied low, opcodes 12-14 behave as NOP and depth wraps.
//  Ports    : clk, rst (async, active-high)   clock / reset
//             start                            leave IDLE/HALTED, begin fetch
//             inst[3:0]                        opcode field of IR (used in ID)
//             ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite,
//             J, JZ, write_enable              datapath strobes
//             ALUop[ALU_OP_W-1:0]              ALU operation select
//             busy, halted, fault              status
//             depth[DEPTH_W-1:0]               current stack occupancy
//  Revision : 2.0 - opcode space, ALU width param, handshake, depth tracking
// ============================================================================
module stack_ctrl_v2 #(
   parameter int STACK_DEPTH = 16,
   parameter int ALU_OP_W    = 3,
   parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [3:0]          inst,
   output logic                ld_IR,
   output logic                PCorIR,
   output logic                push,
   output logic                pop,
   output logic                MEMorALU,
   output logic                ldA,
   output logic                ldB,
   output logic                PCup,
   output logic                PCwrite,
   output logic                J,
   output logic                JZ,
   output logic                write_enable,
   output logic [ALU_OP_W-1:0] ALUop,
   output logic                busy,
   output logic                halted,
   output logic                fault,
   output logic [DEPTH_W-1:0]  depth
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_IF     = 3'd1,
      S_ID     = 3'd2,
      S_EXEC   = 3'd3,
      S_INC0   = 3'd4,
      S_INC1   = 3'd5,
      S_HALTED = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_NOT  = 4'd3;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_POP  = 4'd5;
   localparam logic [3:0] OP_JUMP = 4'd6;
   localparam logic [3:0] OP_JZ   = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_DUP  = 4'd10;
   localparam logic [3:0] OP_HALT = 4'd15;

   state_t     state, state_nxt;
   logic [2:0] step;
   logic [3:0] op;
   logic [2:0] last_step;   // final EXEC step index of the latched opcode
   logic       exec_to_if;  // jumps return straight to IF, skipping INC0/INC1
   logic [2:0] bin_alu;     // ALU code of a binary opcode
   logic       guard_fail;

   // ---------------------------------------------------------------- state regs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         step  <= 3'd0;
         op    <= 4'd0;
      end else begin
         state <= state_nxt;
         // step only advances while staying in EXEC; any other move clears it
         if (state == S_EXEC && state_nxt == S_EXEC)
            step <= step + 3'd1;
         else
            step <= 3'd0;
         if (state == S_ID)
            op <= inst;
      end
   end

   // ---------------------------------------------------------- opcode decode
   always_comb begin
      last_step  = 3'd0;
      exec_to_if = 1'b0;
      bin_alu    = 3'd0;
      case (op)
         OP_ADD:  begin last_step = 3'd4; bin_alu = 3'd0; end
         OP_SUB:  begin last_step = 3'd4; bin_alu = 3'd1; end
         OP_AND:  begin last_step = 3'd4; bin_alu = 3'd2; end
         OP_OR:   begin last_step = 3'd4; bin_alu = 3'd4; end
         OP_XOR:  begin last_step = 3'd4; bin_alu = 3'd5; end
         OP_NOT:  last_step = 3'd2;
         OP_DUP:  last_step = 3'd2;
         OP_PUSH: last_step = 3'd1;
         OP_POP:  last_step = 3'd1;
         OP_JUMP: exec_to_if = 1'b1;
         OP_JZ:   begin last_step = 3'd1; exec_to_if = 1'b1; end
         default: last_step = 3'd0;   // NOP, HALT, 12-14
      endcase
   end

   // ------------------------------------------------------- occupancy guard
`ifdef STACK_GUARD_EN
   localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

   // Evaluated on the raw opcode in ID so the offending instruction never
   // reaches EXEC and issues no strobe at all.
   always_comb begin
      guard_fail = 1'b0;
      case (inst)
         OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_XOR:            guard_fail = (depth <= DEPTH_W'(1));
         OP_NOT, OP_POP, OP_JZ:    guard_fail = (depth == '0);
         OP_PUSH:                  guard_fail = (depth >= FULL);
         OP_DUP:                   guard_fail = (depth == '0) || (depth >= FULL);
         4'd12, 4'd13, 4'd14:      guard_fail = 1'b1;
         default:                  guard_fail = 1'b0;
      endcase
   end
`else
   assign guard_fail = 1'b0;
`endif

   // ------------------------------------------------------------ next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_HALTED: if (start) state_nxt = S_IF;
         S_IF:             state_nxt = S_ID;
         S_ID:             state_nxt = guard_fail ? S_FAULT : S_EXEC;
         S_EXEC:           if (step == last_step)
                              state_nxt = exec_to_if ? S_IF : S_INC0;
         S_INC0:           state_nxt = S_INC1;
         S_INC1:           state_nxt = (op == OP_HALT) ? S_HALTED : S_IF;
         S_FAULT:          state_nxt = S_FAULT;
         default:          state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------- Moore outputs
   always_comb begin
      ld_IR        = 1'b0;
      PCorIR       = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      MEMorALU     = 1'b0;
      ldA          = 1'b0;
      ldB          = 1'b0;
      PCup         = 1'b0;
      PCwrite      = 1'b0;
      J            = 1'b0;
      JZ           = 1'b0;
      write_enable = 1'b0;
      ALUop        = '0;
      case (state)
         S_IF:   ld_IR = 1'b1;
         S_EXEC: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  case (step)
                     3'd0: ldA = 1'b1;
                     3'd1: pop = 1'b1;
                     3'd2: ldB = 1'b1;
                     3'd3: begin pop = 1'b1; ALUop = ALU_OP_W'(bin_alu); end
                     3'd4: begin push = 1'b1; MEMorALU = 1'b1; end
                     default: ;
                  endcase
               end
               OP_NOT: begin
                  case (step)
                     3'd0: ldA = 1'b1;
                     3'd1: begin pop = 1'b1; ALUop = ALU_OP_W'(3'd3); end
                     3'd2: begin push = 1'b1; MEMorALU = 1'b1; end
                     default: ;
                  endcase
               end
               OP_PUSH: begin
                  if (step == 3'd0) PCorIR = 1'b1;
                  else              push   = 1'b1;
               end
               OP_POP: begin
                  if (step == 3'd0) ldA = 1'b1;
                  else begin
                     pop          = 1'b1;
                     write_enable = 1'b1;
                     PCorIR       = 1'b1;
                  end
               end
               OP_DUP: begin
                  case (step)
                     3'd0: ldA = 1'b1;
                     3'd1: ALUop = ALU_OP_W'(3'd6);
                     3'd2: begin push = 1'b1; MEMorALU = 1'b1; end
                     default: ;
                  endcase
               end
               OP_JUMP: begin
                  J       = 1'b1;
                  PCwrite = 1'b1;
               end
               OP_JZ: begin
                  if (step == 3'd0) begin ldA = 1'b1; PCup = 1'b1; end
                  else begin JZ = 1'b1; PCwrite = 1'b1; end
               end
               default: ;
            endcase
         end
         S_INC0: PCup = 1'b1;
         S_INC1: begin PCup = 1'b1; PCwrite = 1'b1; end
         default: ;
      endcase
   end

   assign busy   = (state != S_IDLE) && (state != S_HALTED) && (state != S_FAULT);
   assign halted = (state == S_HALTED);
`ifdef STACK_GUARD_EN
   assign fault  = (state == S_FAULT);
`else
   assign fault  = 1'b0;
`endif

   // ---------------------------------------------------------- depth counter
   // push and pop are never issued in the same micro-step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= '0;
      end else if (push) begin
`ifdef STACK_GUARD_EN
         if (depth != FULL) depth <= depth + DEPTH_W'(1);
`else
         depth <= depth + DEPTH_W'(1);
`endif
      end else if (pop) begin
`ifdef STACK_GUARD_EN
         if (depth != '0) depth <= depth - DEPTH_W'(1);
`else
         depth <= depth - DEPTH_W'(1);
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_ctrl_v2
//  Purpose  : Self-checking bench for stack_ctrl_v2 (STACK_DEPTH=4). Opcode
//             tables give per-instruction IF-to-IF cycle counts and expected
//             depth; per-cycle strobe words are queued from a step-table model
//             and compared each cycle. Honours STACK_GUARD_EN.
//  Revision : 1.0
// ============================================================================
module tb_stack_ctrl_v2;

   localparam int SD = 4;
   localparam int DW = $clog2(SD + 1);

   logic          clk = 1'b0;
   logic          rst, start;
   logic [3:0]    inst;
   logic          ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB;
   logic          PCup, PCwrite, J, JZ, write_enable;
   logic [2:0]    ALUop;
   logic          busy, halted, fault;
   logic [DW-1:0] depth;

   stack_ctrl_v2 #(.STACK_DEPTH(SD), .ALU_OP_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .inst(inst),
      .ld_IR(ld_IR), .PCorIR(PCorIR), .push(push), .pop(pop),
      .MEMorALU(MEMorALU), .ldA(ldA), .ldB(ldB), .PCup(PCup),
      .PCwrite(PCwrite), .J(J), .JZ(JZ), .write_enable(write_enable),
      .ALUop(ALUop), .busy(busy), .halted(halted), .fault(fault),
      .depth(depth)
   );

   always #5 clk = ~clk;

   // strobe word layout: {busy, ALUop[2:0], 12 strobes}
   localparam logic [15:0] BSY  = 16'h8000;
   localparam logic [15:0] IR   = 16'h0800;
   localparam logic [15:0] PCI  = 16'h0400;
   localparam logic [15:0] PSH  = 16'h0200;
   localparam logic [15:0] POPS = 16'h0100;
   localparam logic [15:0] MOA  = 16'h0080;
   localparam logic [15:0] LDA  = 16'h0040;
   localparam logic [15:0] LDB  = 16'h0020;
   localparam logic [15:0] PCU  = 16'h0010;
   localparam logic [15:0] PCW  = 16'h0008;
   localparam logic [15:0] JMP  = 16'h0004;
   localparam logic [15:0] JZS  = 16'h0002;
   localparam logic [15:0] WE   = 16'h0001;

   typedef struct {
      logic [3:0]    op;
      int            cycles;       // IF-to-next-IF cycle count
      logic [DW-1:0] depth_after;
   } vec_t;

   vec_t          prog_a[4];
   vec_t          prog_b[12];
   logic [15:0]   exp_q[$];
   logic [DW-1:0] depth_m;
   int            checks = 0;
   int            errors = 0;

   function automatic logic [15:0] alu(input int n);
      return 16'(n) << 12;
   endfunction

   function automatic logic [15:0] act_word();
      return {busy, ALUop, ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB,
              PCup, PCwrite, J, JZ, write_enable};
   endfunction

   function automatic int nexec(input logic [3:0] op);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd8, 4'd9: return 5;
         4'd3, 4'd10:                  return 3;
         4'd4, 4'd5, 4'd7:             return 2;
         default:                      return 1;
      endcase
   endfunction

   function automatic logic [15:0] exec_word(input logic [3:0] op, input int s);
      int code;
      case (op)
         4'd1: code = 1;
         4'd2: code = 2;
         4'd8: code = 4;
         4'd9: code = 5;
         default: code = 0;
      endcase
      case (op)
         4'd0, 4'd1, 4'd2, 4'd8, 4'd9:
            case (s)
               0: return LDA;
               1: return POPS;
               2: return LDB;
               3: return POPS | alu(code);
               default: return PSH | MOA;
            endcase
         4'd3:  return (s == 0) ? LDA : (s == 1) ? (POPS | alu(3)) : (PSH | MOA);
         4'd10: return (s == 0) ? LDA : (s == 1) ? alu(6) : (PSH | MOA);
         4'd4:  return (s == 0) ? PCI : PSH;
         4'd5:  return (s == 0) ? LDA : (POPS | WE | PCI);
         4'd6:  return JMP | PCW;
         4'd7:  return (s == 0) ? (LDA | PCU) : (JZS | PCW);
         default: return 16'h0000;
      endcase
   endfunction

   // expected word for cycle k counted from IF
   function automatic logic [15:0] exp_word(input logic [3:0] op, input int k);
      int ne;
      ne = nexec(op);
      if (k == 0)       return BSY | IR;
      if (k == 1)       return BSY;
      if (k - 2 < ne)   return BSY | exec_word(op, k - 2);
      if (k - 2 == ne)  return BSY | PCU;
      return BSY | PCU | PCW;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_cycle(input string tag);
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty actual=%0h required=none", tag, act_word());
      end else begin
         e = exp_q.pop_front();
         if (act_word() !== e) begin
            errors++;
            $display("FAIL %s strobes actual=%h required=%h", tag, act_word(), e);
         end
         chk({tag, "_depth"}, 32'(depth), 32'(depth_m));
         if ((e & PSH) != 16'h0)  depth_m = depth_m + DW'(1);
         if ((e & POPS) != 16'h0) depth_m = depth_m - DW'(1);
      end
   endtask

   // queue and check the first n cycles of an instruction; ends 1 time unit
   // after the edge that closes cycle n-1
   task automatic exec_op(input logic [3:0] op, input int n);
      inst = op;
      for (int k = 0; k < n; k++) exp_q.push_back(exp_word(op, k));
      for (int k = 0; k < n; k++) begin
         check_cycle($sformatf("op%0d_k%0d", op, k));
         @(posedge clk); #1;
      end
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      depth_m = '0;
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      prog_a[0] = '{op: 4'd4,  cycles: 6, depth_after: 3'd1};
      prog_a[1] = '{op: 4'd4,  cycles: 6, depth_after: 3'd2};
      prog_a[2] = '{op: 4'd0,  cycles: 9, depth_after: 3'd1};
      prog_a[3] = '{op: 4'd15, cycles: 5, depth_after: 3'd1};

      prog_b[0]  = '{op: 4'd4,  cycles: 6, depth_after: 3'd2};
      prog_b[1]  = '{op: 4'd8,  cycles: 9, depth_after: 3'd1};
      prog_b[2]  = '{op: 4'd4,  cycles: 6, depth_after: 3'd2};
      prog_b[3]  = '{op: 4'd9,  cycles: 9, depth_after: 3'd1};
      prog_b[4]  = '{op: 4'd3,  cycles: 7, depth_after: 3'd1};
      prog_b[5]  = '{op: 4'd10, cycles: 7, depth_after: 3'd2};
      prog_b[6]  = '{op: 4'd2,  cycles: 9, depth_after: 3'd1};
      prog_b[7]  = '{op: 4'd6,  cycles: 3, depth_after: 3'd1};
      prog_b[8]  = '{op: 4'd7,  cycles: 4, depth_after: 3'd1};
      prog_b[9]  = '{op: 4'd11, cycles: 5, depth_after: 3'd1};
      prog_b[10] = '{op: 4'd5,  cycles: 6, depth_after: 3'd0};
      prog_b[11] = '{op: 4'd15, cycles: 5, depth_after: 3'd0};

      rst = 1'b1; start = 1'b0; inst = 4'd0; depth_m = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_strobes", 32'(act_word()), 32'h0);
      chk("reset_depth", 32'(depth), 32'h0);
      chk("reset_flags", {30'h0, halted, fault}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_no_start", 32'(act_word()), 32'h0);

      // PUSH, PUSH, ADD, HALT
      start_pulse();
      for (int i = 0; i < 4; i++) begin
         exec_op(prog_a[i].op, prog_a[i].cycles);
         chk($sformatf("a%0d_depth_after", i), 32'(depth), 32'(prog_a[i].depth_after));
      end
      chk("halted_after_prog_a", {30'h0, halted, busy}, 32'h2);
      @(posedge clk); #1;
      chk("halted_hold", {30'h0, halted, busy}, 32'h2);

      // remaining opcodes; start held high during JUMP must be ignored
      start_pulse();
      for (int i = 0; i < 12; i++) begin
         if (i == 7) start = 1'b1;
         exec_op(prog_b[i].op, prog_b[i].cycles);
         start = 1'b0;
         chk($sformatf("b%0d_depth_after", i), 32'(depth), 32'(prog_b[i].depth_after));
      end
      chk("halted_after_prog_b", {30'h0, halted, busy}, 32'h2);

      // asynchronous reset in step 3 of SUB
      start_pulse();
      exec_op(4'd4, 6);
      exec_op(4'd4, 6);
      exec_op(4'd1, 5);
      exp_q.push_back(exp_word(4'd1, 5));
      check_cycle("sub_step3");
      rst = 1'b1;
      #1;
      chk("async_rst_strobes", 32'(act_word()), 32'h0);
      chk("async_rst_depth", 32'(depth), 32'h0);
      chk("async_rst_flags", {30'h0, halted, fault}, 32'h0);
      depth_m = '0;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_rst", 32'(act_word()), 32'h0);
      start_pulse();
      exec_op(4'd4, 6);
      chk("restart_depth", 32'(depth), 32'h1);

      do_reset();
`ifdef STACK_GUARD_EN
      // ADD on an empty stack: IF, ID, then FAULT with no ADD strobe
      start_pulse();
      exec_op(4'd0, 2);
      for (int c = 0; c < 3; c++) begin
         start = 1'b1;
         chk("underflow_flags", {29'h0, fault, busy, halted}, 32'h4);
         chk("underflow_strobes", 32'(act_word()), 32'h0);
         @(posedge clk); #1;
      end
      start = 1'b0;
      do_reset();
      chk("fault_cleared", {31'h0, fault}, 32'h0);
      // fifth PUSH into a full stack
      start_pulse();
      for (int i = 0; i < 4; i++) exec_op(4'd4, 6);
      chk("full_depth", 32'(depth), 32'h4);
      exec_op(4'd4, 2);
      for (int c = 0; c < 3; c++) begin
         chk("overflow_flags", {30'h0, fault, busy}, 32'h2);
         chk("overflow_depth", 32'(depth), 32'h4);
         chk("overflow_strobes", 32'(act_word()), 32'h0);
         @(posedge clk); #1;
      end
`else
      // illegal opcode runs as NOP; depth wraps modulo 8
      start_pulse();
      exec_op(4'd13, 5);
      chk("illegal_nop_depth", 32'(depth), 32'h0);
      for (int i = 0; i < 5; i++) exec_op(4'd4, 6);
      chk("wrap_depth5", 32'(depth), 32'h5);
      chk("no_fault", {31'h0, fault}, 32'h0);
      for (int i = 0; i < 3; i++) exec_op(4'd4, 6);
      chk("wrap_depth0", 32'(depth), 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stack_ctrl_v2.md
# stack_ctrl_v2

Parametrised multicycle controller for the stack-machine datapath: fetches an instruction into IR, decodes a 4-bit opcode and sequences the datapath strobes (IR load, stack push/pop, A/B load, ALU op, PC update) one micro-step per clock. It extends the first-generation controller with:
- A wider opcode space and a parametrised ALU-op width.
- A start/halt handshake.
- An internal stack-depth counter with optional overflow/underflow guarding.

It sits between the instruction memory/IR and the stack datapath.

## Interface
Parameters:
- STACK_DEPTH, 16, number of stack entries; depth counter saturates logic at this value.
- ALU_OP_W, 3, width of ALUop; must be >= 3.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of depth output.

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  leave IDLE/HALTED and begin fetching.
- inst  in  4  opcode field of IR.
- ld_IR, PCorIR, push, pop, MEMorALU, ldA, ldB, PCup, PCwrite, J, JZ, write_enable  out  1 each  datapath strobes, same meaning as first generation.
- ALUop  out  ALU_OP_W  0 ADD, 1 SUB, 2 AND, 3 NOT, 4 OR, 5 XOR, 6 PASS_A.
- busy  out  1  high in every state except IDLE, HALTED, FAULT.
- halted  out  1  high in HALTED.
- fault  out  1  high in FAULT.
- depth  out  DEPTH_W  current stack occupancy.

## Operation
- States: IDLE, IF, ID, EXEC, INC0, INC1, HALTED, FAULT. A step counter (3 bits) cleared on every entry to EXEC, INC0, IF.
- IDLE: start=1 -> IF. IF: ld_IR=1 -> ID. ID: no strobes; opcode latched into op register; -> EXEC (or FAULT, see Configuration).
- EXEC sequences by opcode, step 0 upward:
  - Binary ops (0 ADD, 1 SUB, 2 AND, 8 OR, 9 XOR):
    - step0 ldA.
    - step1 pop.
    - step2 ldB.
    - step3 pop + ALUop.
    - step4 push + MEMorALU.
    - Then -> INC0.
  - 3 NOT:
    - step0 ldA.
    - step1 pop + ALUop=3.
    - step2 push + MEMorALU.
    - Then -> INC0.
  - 4 PUSH: step0 PCorIR; step1 push; -> INC0.
  - 5 POP: step0 ldA; step1 pop + write_enable + PCorIR; -> INC0.
  - 10 DUP: step0 ldA; step1 ALUop=6; step2 push + MEMorALU; -> INC0.
  - 6 JUMP: step0 J + PCwrite; -> IF.
  - 7 JZ: step0 ldA + PCup; step1 JZ + PCwrite; -> IF.
  - 11 NOP: -> INC0 immediately (one idle EXEC cycle).
  - 15 HALT: -> INC0, then HALTED instead of IF.
  - 12–14 illegal: treated as NOP.
- INC0: PCup. INC1: PCup + PCwrite; -> IF (or HALTED after HALT).
- HALTED: no strobes; start=1 -> IF.
- FAULT: all strobes 0; left only by rst.
- depth: +1 on a cycle with push, −1 on a cycle with pop; never both in one cycle. Width-safe, no wrap in guarded build.

## Timing
- Reset (async): state IDLE, step 0, depth 0, every output 0 including ALUop, busy, halted, fault.
- Outputs are Moore: decoded from state/step/op register only; inst is sampled only in ID.
- Cycles from IF to next IF:
  - Binary: 9.
  - NOT, DUP: 7.
  - PUSH, POP: 6.
  - NOP: 5.
  - JUMP: 3.
  - JZ: 4.
- start is ignored while busy. rst mid-instruction aborts instantly; the partial push/pop effect on depth is discarded (depth=0).
- ALUop is held only during its step; the datapath registers the ALU result at that edge.

## Configuration
- STACK_GUARD_EN defined:
  - In ID, checks that required occupancy is present: binary needs depth>=2; NOT/POP/DUP/JZ need depth>=1; PUSH/DUP need depth<STACK_DEPTH (DUP needs both).
  - Illegal opcodes 12–14 go to FAULT.
  - Any violation -> FAULT with fault=1; no strobe of the offending instruction is issued.
- Not defined: no checks, fault tied 0, illegal opcodes are NOP, and depth wraps modulo 2^DEPTH_W.

## Test plan
- Reset then start pulse, PUSH,PUSH,ADD,HALT -> strobe sequence matches step tables; depth 1,2,1; halted=1 after 6+6+9+5 cycles post-start.
- JUMP: J and PCwrite high for exactly one cycle, next cycle ld_IR=1; JZ: ldA+PCup then JZ+PCwrite, 4 cycles total.
- Guard on, empty stack, ADD -> FAULT two cycles after IF (IF, ID, FAULT), pop never asserted, fault=1 until rst.
- Guard on, STACK_DEPTH=4: five PUSHes -> fifth faults with depth=4; guard off -> depth wraps to 5 (mod 8), no fault.
- DUP with depth=1 -> ALUop=6 on step1, push with MEMorALU on step2, depth=2.
- Assert rst during step 3 of SUB -> all outputs 0 asynchronously, state IDLE; start restarts cleanly at IF.
